// File: rtl/channel_pkg.sv
// Shared types for the bundled-data handshake channel.
package channel_pkg;

  // Handshake protocol selected per channel instance.
  typedef enum logic {
    P4PhaseBD = 1'b0,
    P2PhaseBD = 1'b1
  } protocol_e;

  // Channel state. In 2-phase mode only IDLE (ready) and REQ (token
  // outstanding) are used.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2,
    RTZ  = 2'd3
  } state_e;

  localparam int CNT_W = 16;

endpackage

// File: rtl/channel_if.sv
// Sender/receiver handshake bundle for the channel.
//
// Handshake: the sender presents s_data and raises (4-phase) or toggles
// (2-phase) s_req; the channel answers on s_ack. Toward the receiver the
// channel presents r_data and raises/toggles r_req; the receiver answers on
// r_ack. Data is bundled: it is valid for as long as its req offers a token
// and must stay stable until the matching ack.
interface channel_if #(
  parameter int WIDTH = 8
);
  logic             s_req;
  logic [WIDTH-1:0] s_data;
  logic             s_ack;
  logic             r_req;
  logic [WIDTH-1:0] r_data;
  logic             r_ack;

  // Environment side: drives the sender request and the receiver ack.
  modport master (
    output s_req, s_data, r_ack,
    input  s_ack, r_req, r_data
  );

  // Channel side.
  modport slave (
    input  s_req, s_data, r_ack,
    output s_ack, r_req, r_data
  );
endinterface

// File: rtl/channel.sv
// Single-stage bundled-data channel, 4-phase or 2-phase, with an optional
// preloaded token, a transfer counter and a sticky protocol error flag.
module channel
  import channel_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter protocol_e        PROTOCOL   = P4PhaseBD,
  parameter bit               INIT_TOKEN = 1'b0,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  channel_if.slave         ch,
  output logic [CNT_W-1:0] xfer_cnt,
  output logic             err,
  output state_e           state
);

  state_e             state_q;
  logic               s_ack_q;
  logic               r_req_q;
  logic [WIDTH-1:0]   r_data_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               err_q;
  logic               init_pend_q;  // token still to be injected after reset
  logic               preload_q;    // current token came from INIT_VALUE

  generate
    if (PROTOCOL == P4PhaseBD) begin : g_p4
      // 4-phase handshake FSM; every output is a register updated here.
      always_ff @(posedge clk) begin
        if (rst) begin
          state_q     <= IDLE;
          s_ack_q     <= 1'b0;
          r_req_q     <= 1'b0;
          r_data_q    <= '0;
          cnt_q       <= '0;
          err_q       <= 1'b0;
          init_pend_q <= INIT_TOKEN;
          preload_q   <= 1'b0;
        end else begin
          case (state_q)
            IDLE: begin
              if (ch.r_ack) err_q <= 1'b1;
              if (init_pend_q) begin
                r_data_q    <= INIT_VALUE;
                r_req_q     <= 1'b1;
                state_q     <= REQ;
                init_pend_q <= 1'b0;
                preload_q   <= 1'b1;
              end else if (ch.s_req) begin
                r_data_q <= ch.s_data;
                r_req_q  <= 1'b1;
                state_q  <= REQ;
              end
            end
            REQ: begin
              // Sender withdrew its request before being acknowledged.
              if (!preload_q && !ch.s_req) err_q <= 1'b1;
              if (ch.r_ack) begin
                cnt_q <= cnt_q + 1'b1;
                if (preload_q) begin
                  // No sender behind a preloaded token: skip ACK, keep s_ack low.
                  r_req_q <= 1'b0;
                  state_q <= RTZ;
                end else begin
                  s_ack_q <= 1'b1;
                  state_q <= ACK;
                end
              end
            end
            ACK: begin
              if (!ch.s_req) begin
                r_req_q <= 1'b0;
                state_q <= RTZ;
              end
            end
            RTZ: begin
              if (!ch.r_ack) begin
                s_ack_q   <= 1'b0;
                preload_q <= 1'b0;
                state_q   <= IDLE;
              end
            end
            default: state_q <= IDLE;
          endcase
        end
      end
    end else begin : g_p2
      logic s_lvl_q;  // last accepted s_req level

      // 2-phase transition signalling; IDLE = ready, REQ = token outstanding.
      always_ff @(posedge clk) begin
        if (rst) begin
          state_q     <= IDLE;
          s_ack_q     <= 1'b0;
          r_req_q     <= 1'b0;
          r_data_q    <= '0;
          cnt_q       <= '0;
          err_q       <= 1'b0;
          init_pend_q <= INIT_TOKEN;
          preload_q   <= 1'b0;
          s_lvl_q     <= 1'b0;
        end else if (state_q == IDLE) begin
          if (init_pend_q) begin
            r_data_q    <= INIT_VALUE;
            r_req_q     <= ~r_req_q;
            state_q     <= REQ;
            init_pend_q <= 1'b0;
            preload_q   <= 1'b1;
          end else if (ch.s_req != s_lvl_q) begin
            s_lvl_q  <= ch.s_req;
            r_data_q <= ch.s_data;
            r_req_q  <= ~r_req_q;
            state_q  <= REQ;
          end
        end else if (ch.r_ack == r_req_q) begin
          if (!preload_q) s_ack_q <= ~s_ack_q;
          preload_q <= 1'b0;
          cnt_q     <= cnt_q + 1'b1;
          state_q   <= IDLE;
        end
      end
    end
  endgenerate

  assign ch.s_ack  = s_ack_q;
  assign ch.r_req  = r_req_q;
  assign ch.r_data = r_data_q;
  assign xfer_cnt  = cnt_q;
  assign err       = err_q;
  assign state     = state_q;

endmodule

// File: tb/tb_channel.sv
// Bench for channel: a 4-phase instance, a 4-phase instance with a
// preloaded token, and a 2-phase instance, all WIDTH=13.
`timescale 1ns/1ps
module tb_channel;
  import channel_pkg::*;

  localparam int W = 13;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst4, rsti, rst2;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  channel_if #(.WIDTH(W)) if4 ();
  channel_if #(.WIDTH(W)) ifi ();
  channel_if #(.WIDTH(W)) if2 ();

  logic [15:0] cnt4, cnti, cnt2;
  logic        err4, erri, err2;
  state_e      st4, sti, st2;

  channel #(.WIDTH(W), .PROTOCOL(P4PhaseBD)) u_ch4 (
    .clk(clk), .rst(rst4), .ch(if4), .xfer_cnt(cnt4), .err(err4), .state(st4));
  channel #(.WIDTH(W), .PROTOCOL(P4PhaseBD), .INIT_TOKEN(1'b1), .INIT_VALUE(13'h0)) u_chi (
    .clk(clk), .rst(rsti), .ch(ifi), .xfer_cnt(cnti), .err(erri), .state(sti));
  channel #(.WIDTH(W), .PROTOCOL(P2PhaseBD)) u_ch2 (
    .clk(clk), .rst(rst2), .ch(if2), .xfer_cnt(cnt2), .err(err2), .state(st2));

  // ---------------- scoreboard ----------------
  int             checks   = 0;
  int             failures = 0;
  logic [W-1:0]   exp_q[$];
  int             exp_cnt4 = 0;
  int             exp_cnt2 = 0;
  logic           exp_rreq = 1'b0;
  logic           exp_sack = 1'b0;
  logic           s2_lvl   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return if4.r_req;
      1:       return if4.s_ack;
      2:       return if2.r_req;
      default: return if2.s_ack;
    endcase
  endfunction

  // Bounded wait for a handshake level; an expired bound shows as a failed check.
  task automatic wait_lvl(input string tag, input int sel, input logic lvl);
    int k = 0;
    while (sig(sel) !== lvl && k < 20) begin
      step();
      k++;
    end
    chk(tag, sig(sel), lvl);
  endtask

  // One complete 4-phase transfer; 'later' replaces s_data after capture.
  task automatic xfer4(input logic [W-1:0] v, input logic [W-1:0] later, input bit rnd);
    if4.s_req  = 1'b1;
    if4.s_data = v;
    exp_q.push_back(v);
    step();
    chk("p4_r_req_latency", if4.r_req, 1);
    chk("p4_r_data", if4.r_data, exp_q.pop_front());
    if4.s_data = later;
    if (rnd) step($urandom_range(0, 3));
    if4.r_ack = 1'b1;
    exp_cnt4++;
    wait_lvl("p4_s_ack_rise", 1, 1'b1);
    chk("p4_cnt", cnt4, exp_cnt4);
    chk("p4_r_data_hold", if4.r_data, v);
    if (rnd) step($urandom_range(0, 2));
    if4.s_req = 1'b0;
    wait_lvl("p4_r_req_fall", 0, 1'b0);
    if (rnd) step($urandom_range(0, 2));
    if4.r_ack = 1'b0;
    wait_lvl("p4_s_ack_fall", 1, 1'b0);
  endtask

  // One complete 2-phase transfer.
  task automatic xfer2(input logic [W-1:0] v, input bit rnd);
    s2_lvl     = ~s2_lvl;
    if2.s_req  = s2_lvl;
    if2.s_data = v;
    exp_q.push_back(v);
    exp_rreq = ~exp_rreq;
    step();
    chk("p2_r_req", if2.r_req, exp_rreq);
    chk("p2_r_data", if2.r_data, exp_q.pop_front());
    if2.s_data = W'($urandom_range(0, 8191));
    if (rnd) step($urandom_range(0, 3));
    chk("p2_r_req_hold", if2.r_req, exp_rreq);
    if2.r_ack = exp_rreq;
    exp_sack  = ~exp_sack;
    exp_cnt2++;
    wait_lvl("p2_s_ack", 3, exp_sack);
    chk("p2_cnt", cnt2, exp_cnt2);
    chk("p2_r_data_hold", if2.r_data, v);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int  c0;
    bit  saw_ack;

    rst4 = 1'b1; rsti = 1'b1; rst2 = 1'b1;
    if4.s_req = 1'b0; if4.s_data = '0; if4.r_ack = 1'b0;
    ifi.s_req = 1'b0; ifi.s_data = '0; ifi.r_ack = 1'b0;
    if2.s_req = 1'b0; if2.s_data = '0; if2.r_ack = 1'b0;
    step(2);
    rst4 = 1'b0; rst2 = 1'b0;

    // Reset state.
    chk("rst_r_req", if4.r_req, 0);
    chk("rst_s_ack", if4.s_ack, 0);
    chk("rst_r_data", if4.r_data, 0);
    chk("rst_cnt", cnt4, 0);
    chk("rst_err", err4, 0);
    chk("rst_state", st4, IDLE);
    step();

    // Single transfer of 0x00A, ending in IDLE.
    xfer4(13'h00A, 13'h1FF, 1'b0);
    chk("single_idle", st4, IDLE);
    chk("single_r_req", if4.r_req, 0);

    // Six back-to-back transfers at 4 cycles each.
    c0 = cyc;
    for (int i = 1; i <= 6; i++) xfer4(W'(i), W'(i + 100), 1'b0);
    chk("b2b_cycles", cyc - c0, 24);
    chk("b2b_cnt", cnt4, 7);
    chk("b2b_err", err4, 0);
    chk("b2b_r_data_held", if4.r_data, 6);

    // Sender data changes from 5 to 9 while the token is offered.
    xfer4(13'd5, 13'd9, 1'b0);
    chk("ignore_late_data", if4.r_data, 5);

    // Randomised transfers.
    for (int i = 0; i < 30; i++)
      xfer4(W'($urandom_range(0, 8191)), W'($urandom_range(0, 8191)), 1'b1);
    chk("rnd_cnt", cnt4, exp_cnt4);
    chk("rnd_err", err4, 0);

    // r_ack in IDLE sets a sticky error; channel keeps working.
    if4.r_ack = 1'b1;
    step();
    chk("err_ack_idle", err4, 1);
    if4.r_ack = 1'b0;
    step(3);
    chk("err_sticky", err4, 1);
    xfer4(13'h0F0, 13'h00F, 1'b0);
    chk("err_still_works", cnt4, exp_cnt4);
    chk("err_still_set", err4, 1);
    rst4 = 1'b1;
    step();
    rst4 = 1'b0;
    exp_cnt4 = 0;
    chk("err_cleared", err4, 0);
    chk("cnt_cleared", cnt4, 0);

    // s_req withdrawn while in REQ.
    if4.s_req = 1'b1;
    if4.s_data = 13'h123;
    step();
    if4.s_req = 1'b0;
    step();
    chk("err_sreq_fall", err4, 1);
    if4.r_ack = 1'b1;
    exp_cnt4++;
    wait_lvl("fall_s_ack", 1, 1'b1);
    wait_lvl("fall_r_req", 0, 1'b0);
    if4.r_ack = 1'b0;
    wait_lvl("fall_s_ack_low", 1, 1'b0);
    chk("fall_cnt", cnt4, exp_cnt4);

    // Reset mid-transfer aborts without counting.
    rst4 = 1'b1;
    step();
    rst4 = 1'b0;
    if4.s_req = 1'b1;
    if4.s_data = 13'h0AA;
    step();
    chk("abort_pre_r_req", if4.r_req, 1);
    rst4 = 1'b1;
    if4.s_req = 1'b0;
    step();
    rst4 = 1'b0;
    chk("abort_r_req", if4.r_req, 0);
    chk("abort_r_data", if4.r_data, 0);
    chk("abort_cnt", cnt4, 0);
    chk("abort_state", st4, IDLE);

    // Preloaded token.
    rsti = 1'b0;
    step();
    chk("init_r_req", ifi.r_req, 1);
    chk("init_r_data", ifi.r_data, 0);
    step(3);
    chk("init_r_req_held", ifi.r_req, 1);
    saw_ack = ifi.s_ack;
    ifi.r_ack = 1'b1;
    step();
    saw_ack |= ifi.s_ack;
    chk("init_r_req_fall", ifi.r_req, 0);
    chk("init_cnt", cnti, 1);
    ifi.r_ack = 1'b0;
    step();
    saw_ack |= ifi.s_ack;
    chk("init_idle", sti, IDLE);
    step(2);
    saw_ack |= ifi.s_ack;
    chk("init_no_s_ack", saw_ack, 0);
    ifi.s_req = 1'b1;
    ifi.s_data = 13'h077;
    step();
    chk("init_next_data", ifi.r_data, 13'h077);
    ifi.r_ack = 1'b1;
    step();
    chk("init_next_s_ack", ifi.s_ack, 1);
    ifi.s_req = 1'b0;
    step();
    ifi.r_ack = 1'b0;
    step();
    chk("init_next_cnt", cnti, 2);
    rsti = 1'b1;
    step();
    rsti = 1'b0;
    step();
    chk("init_reissue", ifi.r_req, 1);
    chk("init_reissue_cnt", cnti, 0);
    chk("init_err", erri, 0);

    // 2-phase.
    chk("p2_rst_r_req", if2.r_req, 0);
    chk("p2_rst_s_ack", if2.s_ack, 0);
    xfer2(13'd3, 1'b0);
    xfer2(13'd4, 1'b0);
    chk("p2_two_cnt", cnt2, 2);
    step(3);
    chk("p2_quiet_cnt", cnt2, 2);
    chk("p2_quiet_s_ack", if2.s_ack, exp_sack);
    for (int i = 0; i < 20; i++) xfer2(W'($urandom_range(0, 8191)), 1'b1);
    chk("p2_rnd_cnt", cnt2, exp_cnt2);
    chk("p2_err", err2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/channel.md
CHANNEL -- requirements
Module: channel

Interface
REQ-001 Parameter WIDTH, default 8, payload width in bits.
REQ-002 Parameter PROTOCOL, default P4PhaseBD, handshake protocol: P4PhaseBD (4-phase bundled data) or P2PhaseBD (2-phase bundled data).
REQ-003 Parameter INIT_TOKEN, default 0, when 1 the channel emits one preloaded token after reset.
REQ-004 Parameter INIT_VALUE, default 0, WIDTH-bit payload of the preloaded token.
REQ-005 Ports: one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 s_req  input  1  sender request.
REQ-009 s_data  input  WIDTH  sender payload, bundled with s_req.
REQ-010 s_ack  output  1  acknowledge to sender.
REQ-011 r_req  output  1  request to receiver.
REQ-012 r_data  output  WIDTH  payload to receiver, valid while a token is offered.
REQ-013 r_ack  input  1  receiver acknowledge.
REQ-014 xfer_cnt  output  16  completed transfers, wraps 65535->0.
REQ-015 err  output  1  sticky protocol-violation flag.

Function
REQ-016 All outputs SHALL be registered; each state transition SHALL take exactly one clock edge; an input is acted on at the first edge where it is sampled.
REQ-017 4-phase states: IDLE (r_req=0, s_ack=0), REQ (r_req=1, s_ack=0), ACK (r_req=1, s_ack=1), RTZ (r_req=0, s_ack=1).
REQ-018 IDLE with s_req=1: latch s_data into r_data, go to REQ, so r_req rises one cycle after s_req is sampled.
REQ-019 REQ with r_ack=1: go to ACK, increment xfer_cnt.
REQ-020 ACK with s_req=0: go to RTZ.
REQ-021 RTZ with r_ack=0: go to IDLE.
REQ-022 r_data SHALL hold the latched value from capture until the next capture; later s_data changes SHALL be ignored.
REQ-023 2-phase mode: a transfer starts when s_req differs from the last accepted s_req level.
REQ-024 2-phase mode: on start, latch s_data and toggle r_req.
REQ-025 2-phase mode: when r_ack equals r_req, toggle s_ack, increment xfer_cnt, and become ready for the next transfer.
REQ-026 err SHALL set on r_ack=1 in IDLE (4-phase).
REQ-027 err SHALL set on s_req falling while in REQ (4-phase).
REQ-028 After setting err, operation SHALL continue unchanged; err SHALL clear only on reset.
REQ-029 Preloaded token (INIT_TOKEN=1): on the first cycle after reset, load INIT_VALUE into r_data and enter REQ.
REQ-030 Preloaded token: after r_ack, the sender side SHALL not be acknowledged; ACK is skipped and the channel goes directly to RTZ/IDLE.
REQ-031 Preloaded token: the transfer counts in xfer_cnt.
REQ-032 Back-to-back transfers SHALL be supported without idle cycles beyond those forced by the handshake (4-phase minimum 4 cycles per transfer).

Reset
REQ-033 rst=1 at a rising edge SHALL force: state IDLE, s_ack=0, r_req=0, r_data=0, xfer_cnt=0, err=0, and the 2-phase tracking levels to 0.
REQ-034 Reset mid-transfer SHALL abort the transfer silently without counting it.
REQ-035 A preloaded token, if enabled, SHALL be re-issued after every reset.

Structure
REQ-036 A shared package SHALL hold the protocol enum {P4PhaseBD, P2PhaseBD} and the state enum {IDLE, REQ, ACK, RTZ}.
REQ-037 The block SHALL be a single module with no sub-modules; 2-phase logic is a generate branch selected by PROTOCOL.

Verification
REQ-038 4-phase, WIDTH=13: s_req=1 with s_data=0x00A -> r_req=1 next cycle, r_data=0x00A; r_ack=1 -> s_ack=1, xfer_cnt=1; full return-to-zero ends in IDLE.
REQ-039 Six back-to-back 4-phase transfers of values 1..6 -> receiver sees 1..6 in order, xfer_cnt=6, err=0.
REQ-040 Change s_data from 5 to 9 while in REQ -> r_data stays 5.
REQ-041 INIT_TOKEN=1, INIT_VALUE=0 -> after reset r_req=1 with r_data=0 and no sender activity; r_ack completes it, s_ack never pulses, xfer_cnt=1.
REQ-042 r_ack=1 in IDLE -> err=1 and stays 1; rst -> err=0.
REQ-043 2-phase: toggle s_req 0->1 with data 3, then 1->0 with data 4 -> r_req toggles twice, receiver sees 3 then 4, xfer_cnt=2.
